// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROR): applies one log-shift stage per clock, sequenced by a small FSM.
// Optional build macro SHIFT_SEQ_EARLY_EXIT_EN: stop once the remaining shift-amount bits are all zero.
module shift_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [1:0]          i_op,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [SHAMT_W-1:0]  i_shamt,
    input  logic                i_flush,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   o_result,
    output logic                o_busy
);

    localparam int K_W = 3;
    localparam logic [K_W-1:0] K_LAST = K_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state_q;
    logic [K_W-1:0]      k_q;
    logic [DATA_W-1:0]   data_q;
    logic [SHAMT_W-1:0]  shamt_q;
    logic [1:0]          op_q;
    logic                sign_q;
    logic [DATA_W-1:0]   result_q;
    logic                valid_q;
    logic                ready_q;
    logic                busy_q;

    logic [DATA_W-1:0]   stage_res [SHAMT_W];
    logic [DATA_W-1:0]   stage_sel;
    logic [DATA_W-1:0]   data_d;
    logic                last_step;

    // Stage gi shifts by 2^gi; only the stage selected by k_q is used each cycle.
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
        localparam int N = 1 << gi;
        assign stage_res[gi] =
            (op_q == 2'b00) ? (data_q << N) :
            (op_q == 2'b01) ? (data_q >> N) :
            (op_q == 2'b10) ? {{N{sign_q}}, data_q[DATA_W-1:N]} :
                              {data_q[N-1:0], data_q[DATA_W-1:N]};
    end

    always_comb begin
        stage_sel = data_q;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (k_q == i[K_W-1:0]) begin
                stage_sel = stage_res[i];
            end
        end
        data_d = shamt_q[k_q] ? stage_sel : data_q;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        last_step = ((shamt_q >> (k_q + 3'd1)) == '0);
`else
        last_step = (k_q == K_LAST);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            data_q   <= '0;
            shamt_q  <= '0;
            op_q     <= 2'b00;
            sign_q   <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // A flush in IDLE suppresses a same-cycle request.
                    if (!i_flush && i_valid) begin
                        data_q  <= i_a;
                        shamt_q <= i_shamt;
                        op_q    <= i_op;
                        sign_q  <= i_a[DATA_W-1];
                        k_q     <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
                        if (i_shamt == '0) begin
                            state_q  <= S_DONE;
                            valid_q  <= 1'b1;
                            result_q <= i_a;
                        end else begin
                            state_q  <= S_BUSY;
                        end
`else
                        state_q <= S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    if (i_flush) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        data_q <= data_d;
                        if (last_step) begin
                            state_q  <= S_DONE;
                            valid_q  <= 1'b1;
                            result_q <= data_d;
                        end else begin
                            k_q <= k_q + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (i_flush || i_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: table of shift vectors plus handshake, flush and reset sequences.
// Honours SHIFT_SEQ_EARLY_EXIT_EN for the expected latency.
module tb_shift_seq_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [4:0]  i_shamt;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    shift_seq_ctrl #(.DATA_W(32), .SHAMT_W(5)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_shamt  (i_shamt),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Extra edges after the accept edge before o_valid is seen.
    function automatic int exp_lat(input logic [4:0] shamt);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        int m;
        if (shamt == 5'd0) return 0;
        m = 0;
        for (int b = 0; b < 5; b++) if (shamt[b]) m = b;
        return m + 1;
`else
        return 5;
`endif
    endfunction

    // Issue a request and wait (bounded) for o_valid; leaves the unit in DONE.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [4:0] shamt,
                         output int lat);
        @(negedge i_clk);
        chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
        i_op = op; i_a = a; i_shamt = shamt; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    task automatic complete(input string tag, input logic [31:0] exp);
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, o_ready}, 32'd1);
        chk({tag, "_busy_drop"},  {31'd0, o_busy},  32'd0);
        chk({tag, "_result_hold"}, o_result, exp);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] last_res;

        vecs[0]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
        vecs[1]  = '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[2]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[3]  = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000};
        vecs[4]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[5]  = '{2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678};
        vecs[6]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[7]  = '{2'b01, 32'hF000_0000, 5'd16, 32'h0000_F000};
        vecs[8]  = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
        vecs[9]  = '{2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456};
        vecs[10] = '{2'b00, 32'h0000_00FF, 5'd3,  32'h0000_07F8};
        vecs[11] = '{2'b10, 32'h8000_0001, 5'd16, 32'hFFFF_8000};
        vecs[12] = '{2'b11, 32'h8000_0001, 5'd4,  32'h1800_0000};

        i_rst_n = 1'b0; i_valid = 1'b0; i_op = 2'b00; i_a = '0;
        i_shamt = '0; i_flush = 1'b0; i_ready = 1'b0;
        #2;
        chk("rst_valid",  {31'd0, o_valid}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_busy",   {31'd0, o_busy},  32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("post_rst_ready", {31'd0, o_ready}, 32'd1);

        for (int v = 0; v < 13; v++) begin
            issue(vecs[v].op, vecs[v].a, vecs[v].shamt, lat);
            $display("vec %0d op=%0d a=0x%08h shamt=%0d result=0x%08h exp=0x%08h lat=%0d",
                     v, vecs[v].op, vecs[v].a, vecs[v].shamt, o_result, vecs[v].exp, lat);
            chk($sformatf("vec%0d_result", v), o_result, vecs[v].exp);
            chk($sformatf("vec%0d_latency", v), lat, exp_lat(vecs[v].shamt));
            chk($sformatf("vec%0d_busy_done", v), {31'd0, o_busy}, 32'd1);
            complete($sformatf("vec%0d", v), vecs[v].exp);
        end
        last_res = vecs[12].exp;

        // Backpressure: result held, new requests ignored while DONE.
        issue(2'b01, 32'hF000_0000, 5'd16, lat);
        chk("bp_result", o_result, 32'h0000_F000);
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            i_valid = 1'b1; i_a = 32'hAAAA_5555; i_shamt = 5'd0; i_op = 2'b00;
            @(posedge i_clk); #1;
            chk($sformatf("bp%0d_valid", c), {31'd0, o_valid}, 32'd1);
            chk($sformatf("bp%0d_result", c), o_result, 32'h0000_F000);
            chk($sformatf("bp%0d_ready", c), {31'd0, o_ready}, 32'd0);
        end
        i_valid = 1'b0;
        $display("backpressure held 10 cycles result=0x%08h", o_result);
        complete("bp", 32'h0000_F000);
        last_res = 32'h0000_F000;

        // Flush in the 3rd BUSY cycle: no valid pulse, o_result unchanged.
        @(negedge i_clk);
        i_op = 2'b00; i_a = 32'h0000_0001; i_shamt = 5'd8; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("fl_busy_c1", {31'd0, o_busy}, 32'd1);
        chk("fl_ready_c1", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        chk("fl_idle_busy", {31'd0, o_busy}, 32'd0);
        chk("fl_idle_ready", {31'd0, o_ready}, 32'd1);
        chk("fl_result", o_result, last_res);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge i_clk); #1;
            if (o_valid) pulses++;
        end
        chk("fl_no_valid_pulse", pulses, 0);
        $display("flush mid-busy result=0x%08h pulses=%0d", o_result, pulses);
        issue(2'b00, 32'h0000_0001, 5'd8, lat);
        chk("post_fl_result", o_result, 32'h0000_0100);
        chk("post_fl_latency", lat, exp_lat(5'd8));
        complete("post_fl", 32'h0000_0100);

        // Flush wins over a same-cycle request in IDLE.
        @(negedge i_clk);
        i_valid = 1'b1; i_flush = 1'b1; i_op = 2'b01; i_a = 32'h1; i_shamt = 5'd1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        chk("idle_fl_busy", {31'd0, o_busy}, 32'd0);
        chk("idle_fl_ready", {31'd0, o_ready}, 32'd1);
        $display("idle flush+valid busy=%0d", o_busy);

        // Flush together with i_ready in DONE completes the transfer.
        issue(2'b11, 32'h0000_000F, 5'd4, lat);
        chk("done_fl_result", o_result, 32'hF000_0000);
        @(negedge i_clk);
        i_flush = 1'b1; i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_ready = 1'b0;
        chk("done_fl_valid", {31'd0, o_valid}, 32'd0);
        chk("done_fl_ready", {31'd0, o_ready}, 32'd1);
        chk("done_fl_hold", o_result, 32'hF000_0000);
        $display("done flush+ready result=0x%08h", o_result);

        // Reset mid-BUSY returns immediately to the reset state.
        @(negedge i_clk);
        i_op = 2'b00; i_a = 32'h0000_0003; i_shamt = 5'd31; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_result", o_result, 32'd0);
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rel_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rel_rst_result", o_result, 32'd0);
        chk("rel_rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rel_rst_busy", {31'd0, o_busy}, 32'd0);
        $display("reset mid-busy result=0x%08h ready=%0d", o_result, o_ready);

        // Latency boundaries for the early-exit build (fixed build expects 5 everywhere).
        issue(2'b01, 32'hFFFF_FFFF, 5'd3, lat);
        chk("lat3_result", o_result, 32'h1FFF_FFFF);
        chk("lat3_latency", lat, exp_lat(5'd3));
        complete("lat3", 32'h1FFF_FFFF);
        issue(2'b00, 32'h0000_ABCD, 5'd16, lat);
        chk("lat16_result", o_result, 32'hABCD_0000);
        chk("lat16_latency", lat, exp_lat(5'd16));
        complete("lat16", 32'hABCD_0000);
        $display("latency boundary ops done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
